// File: rtl/sha_msg_pad.sv
// sha_msg_pad: byte-stream front end for the SHA-224/256 compression core.
// Packs bytes into 512-bit blocks, applies FIPS 180-4 padding and chains blocks via Enable/Ready.
module sha_msg_pad (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  input  logic [1:0]   op,
  output logic [511:0] Data,
  output logic [63:0]  Index,
  output logic [1:0]   Operation,
  output logic         Enable,
  input  logic [255:0] Hash,
  input  logic         Ready,
  output logic [255:0] digest,
  output logic         digest_valid
);

  localparam logic [2:0] S_FILL  = 3'd0;
  localparam logic [2:0] S_PAD   = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  logic [2:0]   r_state;
  logic [2:0]   w_stateNext;
  logic [511:0] r_buf;
  logic [6:0]   r_cnt;
  logic [63:0]  r_bitlen;
  logic [63:0]  r_blkIdx;
  logic         r_markDone;
  logic         r_final;
  logic         r_ended;
  logic         r_msgStart;
  logic [1:0]   r_op;
  logic [255:0] r_digest;

  logic         w_accept;
  logic         w_readyHit;
  logic [6:0]   w_cntNext;
  logic [8:0]   w_bytePos;
  logic         w_markHere;
  logic         w_lenFits;
  logic [511:0] w_padBuf;

  // Byte k of a block sits big-endian inside word k/4 of the Data bus.
  function automatic int byteLsb(input int k);
    return (k / 4) * 32 + (3 - (k % 4)) * 8;
  endfunction

  assign in_ready     = (r_state == S_FILL);
  assign Enable       = (r_state == S_ISSUE);
  assign digest_valid = (r_state == S_OUT);
  assign Data         = r_buf;
  assign Index        = r_blkIdx;
  assign Operation    = r_op;
  assign digest       = r_digest;

  assign w_accept   = in_valid && in_ready;
  assign w_readyHit = Ready && (r_state == S_WAIT);
  assign w_cntNext  = r_cnt + 7'd1;
  assign w_bytePos  = {r_cnt[5:2], 5'b00000} + {4'b0000, ~r_cnt[1:0], 3'b000};
  assign w_markHere = !r_markDone && !r_cnt[6];
  assign w_lenFits  = r_markDone || (w_markHere && (r_cnt <= 7'd55));

  // Padding applied to the current buffer in one PAD cycle; a full block with no marker yet passes unchanged.
  always_comb begin
    w_padBuf = r_buf;
    if (r_markDone) begin
      for (int k = 0; k < 56; k++) begin
        w_padBuf[byteLsb(k) +: 8] = 8'h00;
      end
    end else if (w_markHere) begin
      for (int k = 0; k < 64; k++) begin
        if (7'(k) == r_cnt) begin
          w_padBuf[byteLsb(k) +: 8] = 8'h80;
        end else if (7'(k) > r_cnt) begin
          w_padBuf[byteLsb(k) +: 8] = 8'h00;
        end
      end
    end
    if (w_lenFits) begin
      for (int j = 0; j < 8; j++) begin
        w_padBuf[byteLsb(56 + j) +: 8] = r_bitlen[63 - 8 * j -: 8];
      end
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_FILL: begin
        if (w_accept) begin
          if (in_last) begin
            w_stateNext = S_PAD;
          end else if (w_cntNext == 7'd64) begin
            w_stateNext = S_ISSUE;
          end
        end
      end
      S_PAD:   w_stateNext = S_ISSUE;
      S_ISSUE: w_stateNext = S_WAIT;
      S_WAIT: begin
        if (Ready) begin
          if (r_final) begin
            w_stateNext = S_OUT;
          end else if (r_ended) begin
            w_stateNext = S_PAD;
          end else begin
            w_stateNext = S_FILL;
          end
        end
      end
      S_OUT:   w_stateNext = S_FILL;
      default: w_stateNext = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_buf <= '0;
    end else if (w_accept) begin
      r_buf[w_bytePos +: 8] <= in_data;
    end else if (r_state == S_PAD) begin
      r_buf <= w_padBuf;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt    <= 7'd0;
      r_bitlen <= 64'd0;
    end else if (w_accept) begin
      r_cnt    <= w_cntNext;
      r_bitlen <= r_bitlen + 64'd8;
    end else if (w_readyHit) begin
      r_cnt <= 7'd0;
    end else if (r_state == S_OUT) begin
      r_bitlen <= 64'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_blkIdx <= 64'd1;
    end else if (w_readyHit) begin
      r_blkIdx <= r_blkIdx + 64'd1;
    end else if (r_state == S_OUT) begin
      r_blkIdx <= 64'd1;
    end
  end

  // Message-level flags; all return to their idle values once the digest is presented.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_markDone <= 1'b0;
      r_final    <= 1'b0;
      r_ended    <= 1'b0;
      r_msgStart <= 1'b1;
      r_op       <= 2'd0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (w_accept) begin
            r_msgStart <= 1'b0;
            if (r_msgStart) begin
              r_op <= op;
            end
            if (in_last) begin
              r_ended <= 1'b1;
            end else if (w_cntNext == 7'd64) begin
              r_final <= 1'b0;
            end
          end
        end
        S_PAD: begin
          r_final <= w_lenFits;
          if (w_markHere) begin
            r_markDone <= 1'b1;
          end
        end
        S_OUT: begin
          r_markDone <= 1'b0;
          r_final    <= 1'b0;
          r_ended    <= 1'b0;
          r_msgStart <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // SHA-224 exposes only the first seven hash words; the last word is cleared.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_digest <= '0;
    end else if (w_readyHit && r_final) begin
      if (r_op == 2'd0) begin
        r_digest <= {Hash[255:32], 32'h0000_0000};
      end else begin
        r_digest <= Hash;
      end
    end
  end

endmodule

// File: tb/tb_sha_msg_pad.sv
// tb_sha_msg_pad: scoreboard bench for sha_msg_pad with a behavioural SHA-256/224 stub core.
// Expected blocks and digests come from a byte-level padding model plus a reference compression.
module tb_sha_msg_pad;

  typedef logic [7:0] byteQ_t [$];

  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  index;
    logic [1:0]   op;
  } blkExp_t;

  logic         clk;
  logic         rst;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [1:0]   op;
  logic [511:0] Data;
  logic [63:0]  Index;
  logic [1:0]   Operation;
  logic         Enable;
  logic [255:0] Hash;
  logic         Ready;
  logic [255:0] digest;
  logic         digest_valid;

  int assertions = 0;
  int failures   = 0;
  int enablesSeen = 0;
  int realReadies = 0;
  bit coreBusy   = 0;
  bit ignoreBusy = 0;

  blkExp_t      expBlkQ[$];
  logic [255:0] expDigQ[$];

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  sha_msg_pad dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .op           (op),
    .Data         (Data),
    .Index        (Index),
    .Operation    (Operation),
    .Enable       (Enable),
    .Hash         (Hash),
    .Ready        (Ready),
    .digest       (digest),
    .digest_valid (digest_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] shaIv(input logic [1:0] o);
    if (o == 2'd0)
      return {32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
              32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
    return {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
            32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  endfunction

  // Reference compression; block word t is blk[t*32 +: 32], big-endian bytes.
  function automatic logic [255:0] shaCompress(input logic [255:0] hIn, input logic [511:0] blk);
    logic [31:0] w [0:63];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int t = 0; t < 16; t++) w[t] = blk[t * 32 +: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = ror(w[t - 15], 7) ^ ror(w[t - 15], 18) ^ (w[t - 15] >> 3);
      s1 = ror(w[t - 2], 17) ^ ror(w[t - 2], 19) ^ (w[t - 2] >> 10);
      w[t] = w[t - 16] + s0 + w[t - 7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hIn;
    for (int t = 0; t < 64; t++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {a + hIn[255:224], b + hIn[223:192], c + hIn[191:160], d + hIn[159:128],
            e + hIn[127:96],  f + hIn[95:64],   g + hIn[63:32],   h + hIn[31:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic printSummary();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
  endtask

  task automatic abortRun(input string name);
    assertions++;
    failures++;
    $display("[TB] FAIL %s: bound expired at time %0t", name, $time);
    printSummary();
    $finish;
  endtask

  // Byte-level padding model: append 0x80, zero fill to 56 mod 64, then the 64-bit bit length.
  task automatic buildExpected(input byteQ_t msg, input logic [1:0] opVal,
                               input logic [255:0] fixedDig, input bit useFixed);
    byteQ_t       p;
    logic [63:0]  len;
    logic [255:0] h;
    logic [511:0] blk;
    blkExp_t      e;
    p = msg;
    len = 64'(msg.size()) * 64'd8;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    for (int j = 0; j < 8; j++) p.push_back(len[63 - 8 * j -: 8]);
    h = shaIv(opVal);
    for (int b = 0; b < p.size() / 64; b++) begin
      for (int i = 0; i < 16; i++)
        blk[i * 32 +: 32] = {p[b * 64 + 4 * i], p[b * 64 + 4 * i + 1], p[b * 64 + 4 * i + 2], p[b * 64 + 4 * i + 3]};
      e.data  = blk;
      e.index = 64'(b + 1);
      e.op    = opVal;
      expBlkQ.push_back(e);
      h = shaCompress(h, blk);
    end
    if (opVal == 2'd0) h[31:0] = 32'h0;
    expDigQ.push_back(useFixed ? fixedDig : h);
  endtask

  task automatic driveByte(input logic [7:0] b, input logic last, input logic [1:0] opVal);
    int waitCycles;
    waitCycles = 0;
    in_data  = b;
    in_last  = last;
    op       = opVal;
    in_valid = 1'b1;
    while (!in_ready) begin
      @(negedge clk);
      waitCycles++;
      if (waitCycles > 1000) abortRun("in_ready wait");
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Later bytes carry random op values: only the first byte of a message may set Operation.
  task automatic applyStimulus(input byteQ_t msg, input logic [1:0] opVal,
                               input logic [255:0] fixedDig, input bit useFixed, input int gapPct);
    buildExpected(msg, opVal, fixedDig, useFixed);
    for (int i = 0; i < msg.size(); i++) begin
      if (int'($urandom_range(0, 99)) < gapPct) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      driveByte(msg[i], i == msg.size() - 1, (i == 0) ? opVal : 2'($urandom_range(0, 1)));
    end
  endtask

  task automatic strToBytes(input string s, output byteQ_t q);
    q = {};
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
  endtask

  task automatic randBytes(input int n, output byteQ_t q);
    q = {};
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
  endtask

  task automatic drainScoreboard();
    int c;
    c = 0;
    while ((expBlkQ.size() != 0 || expDigQ.size() != 0 || coreBusy) && c < 5000) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    if (c >= 5000) abortRun("scoreboard drain");
  endtask

  // Stub core: real Ready after a variable delay, plus stray Ready pulses while idle.
  initial begin
    logic [255:0] hState;
    Ready  = 1'b0;
    Hash   = '0;
    hState = '0;
    forever begin
      @(posedge clk);
      #1;
      Ready    = 1'b0;
      coreBusy = 1'b0;
      if (Enable) begin
        coreBusy = 1'b1;
        if (Index == 64'd1) hState = shaIv(Operation);
        hState = shaCompress(hState, Data);
        repeat ($urandom_range(8, 40)) begin
          @(posedge clk);
          #1;
        end
        Hash  = hState;
        Ready = 1'b1;
        realReadies++;
      end else if ($urandom_range(0, 7) == 0) begin
        Hash  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        Ready = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT issues a block or a digest.
  initial begin
    blkExp_t      e;
    logic [255:0] d;
    forever begin
      @(negedge clk);
      if (coreBusy && !ignoreBusy) checkOutput("in_ready low while core busy", 512'(in_ready), 512'(0));
      if (Enable) begin
        checkOutput("one Enable per Ready", 512'(enablesSeen), 512'(realReadies));
        enablesSeen++;
        if (expBlkQ.size() == 0) begin
          checkOutput("unexpected Enable", 512'(1), 512'(0));
        end else begin
          e = expBlkQ.pop_front();
          checkOutput("Data", Data, e.data);
          checkOutput("Index", 512'(Index), 512'(e.index));
          checkOutput("Operation", 512'(Operation), 512'(e.op));
        end
      end
      if (digest_valid) begin
        if (expDigQ.size() == 0) begin
          checkOutput("unexpected digest_valid", 512'(1), 512'(0));
        end else begin
          d = expDigQ.pop_front();
          checkOutput("digest", 512'(digest), 512'(d));
        end
      end
    end
  end

  initial begin
    #900000;
    abortRun("global watchdog");
  end

  initial begin
    byteQ_t q;
    int     lens [8] = '{1, 55, 56, 63, 65, 119, 120, 128};
    rst      = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    in_last  = 1'b0;
    op       = 2'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset in_ready", 512'(in_ready), 512'(1));
    checkOutput("reset Enable", 512'(Enable), 512'(0));
    checkOutput("reset digest_valid", 512'(digest_valid), 512'(0));
    checkOutput("reset Data", Data, 512'(0));
    checkOutput("reset digest", 512'(digest), 512'(0));
    checkOutput("reset Index", 512'(Index), 512'(1));
    checkOutput("reset Operation", 512'(Operation), 512'(0));
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] abc SHA-256 / SHA-224, two-block 56-byte vector");
    strToBytes("abc", q);
    applyStimulus(q, 2'd1, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, 1'b1, 0);
    applyStimulus(q, 2'd0, {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0}, 1'b1, 0);
    strToBytes("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", q);
    applyStimulus(q, 2'd1, 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1, 1'b1, 0);
    randBytes(64, q);
    applyStimulus(q, 2'd1, '0, 1'b0, 0);
    drainScoreboard();

    $display("[TB] random messages with input gaps");
    foreach (lens[i]) begin
      randBytes(lens[i], q);
      applyStimulus(q, 2'($urandom_range(0, 1)), '0, 1'b0, 30);
    end
    for (int i = 0; i < 4; i++) begin
      randBytes(int'($urandom_range(1, 200)), q);
      applyStimulus(q, 2'($urandom_range(0, 1)), '0, 1'b0, 30);
    end
    drainScoreboard();

    $display("[TB] reset while waiting on the core");
    begin
      blkExp_t e;
      int      c;
      randBytes(64, q);
      for (int i = 0; i < 16; i++) e.data[i * 32 +: 32] = {q[4 * i], q[4 * i + 1], q[4 * i + 2], q[4 * i + 3]};
      e.index = 64'd1;
      e.op    = 2'd1;
      expBlkQ.push_back(e);
      for (int i = 0; i < 64; i++) driveByte(q[i], 1'b0, 2'd1);
      c = 0;
      while (!coreBusy) begin
        @(negedge clk);
        c++;
        if (c > 200) abortRun("core start");
      end
      repeat (2) @(negedge clk);
      ignoreBusy = 1'b1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("post-reset in_ready", 512'(in_ready), 512'(1));
      checkOutput("post-reset Index", 512'(Index), 512'(1));
      checkOutput("post-reset Enable", 512'(Enable), 512'(0));
      checkOutput("post-reset digest_valid", 512'(digest_valid), 512'(0));
      rst = 1'b1;
      c = 0;
      while (coreBusy) begin
        @(negedge clk);
        c++;
        if (c > 200) abortRun("stale core finish");
      end
      ignoreBusy = 1'b0;
      strToBytes("abc", q);
      applyStimulus(q, 2'd1, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, 1'b1, 0);
      drainScoreboard();
    end

    checkOutput("leftover expected blocks", 512'(expBlkQ.size()), 512'(0));
    checkOutput("leftover expected digests", 512'(expDigQ.size()), 512'(0));
    checkOutput("Enable count vs Ready count", 512'(enablesSeen), 512'(realReadies));
    printSummary();
    $finish;
  end

endmodule
